// File: rtl/hp_bar_animator_if.sv
// HP update request channel: the combatant logic (master) to the bar animator (slave).
interface hp_bar_animator_if #(
  parameter int NUM_CH = 2,
  parameter int HP_W   = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            hp_valid;
  logic            hp_ready;
  logic [CH_W-1:0] hp_ch;
  logic [HP_W-1:0] hp_cur;
  logic [HP_W-1:0] hp_max;
  logic            hp_snap;

  modport master (output hp_valid, hp_ch, hp_cur, hp_max, hp_snap, input hp_ready);
  modport slave  (input hp_valid, hp_ch, hp_cur, hp_max, hp_snap, output hp_ready);
endinterface

// File: rtl/hp_bar_animator.sv
// Health-bar animator: scales hp_cur/hp_max to a bar length with a shared
// restoring divider, then walks each channel's displayed bar one pixel per
// animation step toward its target.
module hp_bar_animator #(
  parameter int NUM_CH      = 2,
  parameter int HP_W        = 8,
  parameter int BAR_W       = 6,
  parameter int STEP_FRAMES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_tick,
  hp_bar_animator_if.slave        hp,
  output logic [NUM_CH*BAR_W-1:0] bar_len,
  output logic [NUM_CH*2-1:0]     bar_zone,
  output logic [NUM_CH-1:0]       anim_busy
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NUM_W = HP_W + BAR_W;
  localparam int PRE_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int CNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [BAR_W-1:0] BAR_MAX  = '1;
  localparam logic [BAR_W-1:0] TH_HALF  = BAR_W'((2**BAR_W - 1) / 2);
  localparam logic [BAR_W-1:0] TH_FIFTH = BAR_W'((2**BAR_W - 1) / 5);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAR_W - 1);

  typedef enum logic [1:0] {IDLE, DIV, STORE} state_t;

  state_t          state_q;
  logic [CH_W-1:0] ch_q;
  logic            snap_q;
  logic            cur_zero_q;
  logic            max_zero_q;
  logic [HP_W-1:0] div_q;
  logic [HP_W-1:0] rem_q;
  logic [BAR_W-1:0] low_q;
  logic [BAR_W-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             store;
  logic [HP_W-1:0]  cur_sat;
  logic [NUM_W-1:0] numer;
  logic [HP_W:0]    trial;
  logic             trial_ge;
  logic [HP_W-1:0]  rem_nx;
  logic [BAR_W-1:0] new_tgt;

  assign hp.hp_ready = (state_q == IDLE) && reset_n;
  assign accept      = hp.hp_valid && hp.hp_ready;
  assign store       = (state_q == STORE);

  // Numerator: HP clamped to max, scaled by full bar length
  always_comb begin
    cur_sat = (hp.hp_cur > hp.hp_max) ? hp.hp_max : hp.hp_cur;
    numer   = NUM_W'(cur_sat) * NUM_W'(BAR_MAX);
  end

  // One restoring-division step: bring down next numerator bit, trial subtract
  always_comb begin
    trial    = {rem_q, low_q[BAR_W-1]};
    trial_ge = (trial >= {1'b0, div_q});
    rem_nx   = trial_ge ? HP_W'(trial - {1'b0, div_q}) : trial[HP_W-1:0];
  end

  // Target selection; a living combatant never shows an empty bar
  always_comb begin
    if (max_zero_q || cur_zero_q) new_tgt = '0;
    else if (quo_q == '0)         new_tgt = BAR_W'(1);
    else                          new_tgt = quo_q;
  end

  // Request FSM and divider datapath. The top numerator bits are already
  // below the divisor, so only BAR_W quotient bits remain to be produced.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      snap_q     <= 1'b0;
      cur_zero_q <= 1'b0;
      max_zero_q <= 1'b0;
      div_q      <= '0;
      rem_q      <= '0;
      low_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= DIV;
            ch_q       <= hp.hp_ch;
            snap_q     <= hp.hp_snap;
            cur_zero_q <= (hp.hp_cur == '0);
            max_zero_q <= (hp.hp_max == '0);
            div_q      <= hp.hp_max;
            rem_q      <= numer[NUM_W-1:BAR_W];
            low_q      <= numer[BAR_W-1:0];
            quo_q      <= '0;
            cnt_q      <= '0;
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          low_q <= low_q << 1;
          quo_q <= (quo_q << 1) | BAR_W'(trial_ge);
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= STORE;
        end
        STORE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [BAR_W-1:0] bar_q, bar_d;
    logic [BAR_W-1:0] tgt_q, tgt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       zone;
    logic             hit;

    // Out-of-range channel numbers match no lane, so STORE writes nothing
    assign hit = store && (ch_q == CH_W'(c));

    // Next bar/target/prescaler: STORE beats a coincident animation step
    always_comb begin
      bar_d = bar_q;
      tgt_d = tgt_q;
      pre_d = pre_q;
      if (hit) begin
        tgt_d = new_tgt;
        pre_d = '0;
        if (snap_q) bar_d = new_tgt;
      end else if (bar_q != tgt_q) begin
        if (frame_tick) begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            bar_d = (bar_q < tgt_q) ? bar_q + 1'b1 : bar_q - 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end else begin
        pre_d = '0;
      end
    end

    // Channel state registers; reset shows a full bar
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        bar_q <= BAR_MAX;
        tgt_q <= BAR_MAX;
        pre_q <= '0;
      end else begin
        bar_q <= bar_d;
        tgt_q <= tgt_d;
        pre_q <= pre_d;
      end
    end

    // Colour zone from displayed length
    always_comb begin
      if (bar_q == '0)          zone = 2'b11;
      else if (bar_q > TH_HALF)  zone = 2'b00;
      else if (bar_q > TH_FIFTH) zone = 2'b01;
      else                       zone = 2'b10;
    end

    assign bar_len[c*BAR_W +: BAR_W] = bar_q;
    assign bar_zone[c*2 +: 2]        = zone;
    assign anim_busy[c]              = (bar_q != tgt_q);
  end

endmodule

// File: tb/tb_hp_bar_animator.sv
// Bench for hp_bar_animator: directed table, hand-built corner sequences and
// a random phase, all checked every cycle against a behavioural model.
module tb_hp_bar_animator;
  localparam int NUM_CH  = 2;
  localparam int HP_W    = 8;
  localparam int BAR_W   = 6;
  localparam int STEP    = 1;
  localparam int BAR_MAX = 63;
  localparam int LAT     = BAR_W + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_tick = 1'b0;
  logic [NUM_CH*BAR_W-1:0] bar_len;
  logic [NUM_CH*2-1:0]     bar_zone;
  logic [NUM_CH-1:0]       anim_busy;

  hp_bar_animator_if #(.NUM_CH(NUM_CH), .HP_W(HP_W)) bus();

  hp_bar_animator #(.NUM_CH(NUM_CH), .HP_W(HP_W), .BAR_W(BAR_W), .STEP_FRAMES(STEP)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .hp(bus),
    .bar_len(bar_len), .bar_zone(bar_zone), .anim_busy(anim_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model
  int mbar[NUM_CH];
  int mtgt[NUM_CH];
  int mpre[NUM_CH];
  int mcnt = 0;
  bit macc = 0;
  int pch;
  int pt;
  bit psnap;

  function automatic int ref_target(input int cur, input int mx);
    int cs, q;
    if (mx == 0) return 0;
    if (cur == 0) return 0;
    cs = (cur > mx) ? mx : cur;
    q = cs * BAR_MAX / mx;
    return (q == 0) ? 1 : q;
  endfunction

  function automatic int ref_zone(input int len);
    if (len == 0) return 3;
    if (len > BAR_MAX / 2) return 0;
    if (len > BAR_MAX / 5) return 1;
    return 2;
  endfunction

  task automatic model_edge(input bit tick);
    int sc;
    macc = 0;
    sc = -1;
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mbar[c] = BAR_MAX; mtgt[c] = BAR_MAX; mpre[c] = 0;
      end
      mcnt = 0;
      return;
    end
    if (mcnt > 0) begin
      if (mcnt == 1) sc = pch;
      mcnt--;
    end else if (bus.hp_valid) begin
      pch   = int'(bus.hp_ch);
      psnap = bus.hp_snap;
      pt    = ref_target(int'(bus.hp_cur), int'(bus.hp_max));
      mcnt  = LAT;
      macc  = 1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (c == sc) begin
        mtgt[c] = pt; mpre[c] = 0;
        if (psnap) mbar[c] = pt;
      end else if (mbar[c] != mtgt[c]) begin
        if (tick) begin
          if (mpre[c] == STEP - 1) begin
            mbar[c] += (mbar[c] < mtgt[c]) ? 1 : -1;
            mpre[c] = 0;
          end else mpre[c]++;
        end
      end else mpre[c] = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("hp_ready", int'(bus.hp_ready), (reset_n && mcnt == 0) ? 1 : 0);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("bar_len%0d", c), int'(bar_len[c*BAR_W +: BAR_W]), mbar[c]);
      chk($sformatf("bar_zone%0d", c), int'(bar_zone[c*2 +: 2]), ref_zone(mbar[c]));
      chk($sformatf("anim_busy%0d", c), int'(anim_busy[c]), (mbar[c] != mtgt[c]) ? 1 : 0);
    end
  endtask

  task automatic cyc(input bit tick);
    frame_tick = tick;
    @(posedge clk);
    model_edge(tick);
    #1;
    frame_tick = 1'b0;
    check_all();
  endtask

  // present a request and hold it until accepted; returns in cycle 1
  task automatic send(input int ch, input int cur, input int mx, input bit snap);
    int n;
    n = 0;
    bus.hp_valid = 1'b1;
    bus.hp_ch    = 1'(ch);
    bus.hp_cur   = 8'(cur);
    bus.hp_max   = 8'(mx);
    bus.hp_snap  = snap;
    macc = 0;
    while (!macc && n < 40) begin
      cyc(1'b0);
      n++;
    end
    if (!macc) chk("accept_timeout", 0, 1);
    bus.hp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (mcnt != 0 && n < 40) begin
      cyc(1'b0);
      n++;
    end
    chk("idle_ready", int'(bus.hp_ready), 1);
  endtask

  typedef struct {
    int ch; int cur; int mx; bit snap; int exp_len; int exp_zone;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0,  50,   0, 1,  0, 3};
    tbl[1] = '{0, 200, 100, 1, 63, 0};
    tbl[2] = '{0, 100, 100, 1, 63, 0};
    tbl[3] = '{1,   0,  50, 1,  0, 3};
    tbl[4] = '{0,   1, 100, 1,  1, 2};
    tbl[5] = '{1, 128, 255, 1, 31, 1};
    tbl[6] = '{0,  99, 100, 1, 62, 0};
    tbl[7] = '{1,  40, 100, 1, 25, 1};
    tbl[8] = '{0,  51, 100, 1, 32, 0};
    tbl[9] = '{1,  20, 100, 1, 12, 2};

    for (int c = 0; c < NUM_CH; c++) begin
      mbar[c] = BAR_MAX; mtgt[c] = BAR_MAX; mpre[c] = 0;
    end
    bus.hp_valid = 1'b0; bus.hp_ch = '0; bus.hp_cur = '0; bus.hp_max = '0; bus.hp_snap = 1'b0;

    // 1: reset values, then idle frame ticks change nothing
    reset_n = 1'b0;
    repeat (3) cyc(1'b0);
    reset_n = 1'b1;
    #1;
    chk("t1_ready", int'(bus.hp_ready), 1);
    repeat (10) cyc(1'b1);
    chk("t1_len", int'(bar_len), (63 << 6) | 63);
    chk("t1_zone", int'(bar_zone), 0);
    chk("t1_busy", int'(anim_busy), 0);

    // 2: snap update latency and result
    send(0, 50, 100, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("t2_ready_low_c%0d", k), int'(bus.hp_ready), 0);
      cyc(1'b0);
    end
    chk("t2_ready_c8", int'(bus.hp_ready), 1);
    chk("t2_len0", int'(bar_len[5:0]), 31);
    chk("t2_zone0", int'(bar_zone[1:0]), 1);
    chk("t2_busy0", int'(anim_busy[0]), 0);

    // 3: animated drain to a forced one-pixel target
    send(1, 1, 255, 1'b0);
    wait_idle();
    chk("t3_busy_start", int'(anim_busy[1]), 1);
    repeat (62) cyc(1'b1);
    chk("t3_len1", int'(bar_len[11:6]), 1);
    chk("t3_zone1", int'(bar_zone[3:2]), 2);
    chk("t3_busy_end", int'(anim_busy[1]), 0);

    // 4: table of snapped updates including boundaries
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].ch, tbl[i].cur, tbl[i].mx, tbl[i].snap);
      wait_idle();
      chk($sformatf("tbl%0d_len", i), int'(bar_len[tbl[i].ch*BAR_W +: BAR_W]), tbl[i].exp_len);
      chk($sformatf("tbl%0d_zone", i), int'(bar_zone[tbl[i].ch*2 +: 2]), tbl[i].exp_zone);
    end

    // 5: STORE coincides with a tick on an animating channel; busy-time request ignored
    send(0, 0, 10, 1'b1);
    wait_idle();
    send(0, 10, 10, 1'b0);
    wait_idle();
    repeat (5) cyc(1'b1);
    chk("t5_pre_len0", int'(bar_len[5:0]), 5);
    send(0, 5, 10, 1'b0);
    cyc(1'b0);
    bus.hp_valid = 1'b1; bus.hp_ch = 1'b1; bus.hp_cur = 8'd0; bus.hp_max = 8'd10; bus.hp_snap = 1'b1;
    repeat (3) cyc(1'b0);
    bus.hp_valid = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    chk("t5_no_step", int'(bar_len[5:0]), 5);
    chk("t5_busy0", int'(anim_busy[0]), 1);
    chk("t5_ignored_len1", int'(bar_len[11:6]), 12);
    cyc(1'b1);
    chk("t5_step_after", int'(bar_len[5:0]), 6);

    // 6: reset in the middle of a division
    wait_idle();
    send(1, 10, 20, 1'b1);
    cyc(1'b0);
    cyc(1'b0);
    reset_n = 1'b0;
    cyc(1'b0);
    chk("t6_len", int'(bar_len), (63 << 6) | 63);
    chk("t6_busy", int'(anim_busy), 0);
    chk("t6_ready_in_reset", int'(bus.hp_ready), 0);
    reset_n = 1'b1;
    #1;
    chk("t6_ready_after", int'(bus.hp_ready), 1);
    repeat (10) cyc(1'b1);
    chk("t6_len1_unwritten", int'(bar_len[11:6]), 63);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if (!bus.hp_valid && $urandom_range(0, 3) == 0) begin
        bus.hp_valid = 1'b1;
        bus.hp_ch    = 1'($urandom_range(0, 1));
        bus.hp_cur   = 8'($urandom_range(0, 255));
        bus.hp_max   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        bus.hp_snap  = 1'($urandom_range(0, 1));
      end
      reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cyc($urandom_range(0, 2) == 0);
      if (macc) bus.hp_valid = 1'b0;
    end
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
